fir_seq: RTL

- Sequencer that owns the control port of the 16-tap `fir` datapath (wind/load/in_valid/data, out_valid/out).
- Accepts a coefficient stream and a sample stream through valid/ready handshakes, and drives the `fir` with correctly ordered wind, load and compute pulses.
- Captures each `fir` result into a one-entry result register with a valid/ready handshake.
- Sits between the host/bus-side stream logic and the `fir` instance; testbenches no longer hand-drive the `fir` port.

---
 rtl/fir_pkg.sv | 22 ++
 rtl/fir_seq_res_reg.sv | 43 ++++
 rtl/fir_seq.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared types and sizing helpers for the fir control sequencer.
// Pure declarations: no timing or flow control lives here.
package fir_pkg;

  localparam int FIR_TAPS = 16;
  localparam int FIR_DW   = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WIND = 3'd1,
    FILL = 3'd2,
    LOAD = 3'd3,
    RUN  = 3'd4,
    WAIT = 3'd5
  } fir_seq_state_e;

  // Width of a counter that must be able to hold the value max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fir_seq_res_reg.sv
// One-entry result holding register, filled on load_i and drained on res_valid_o & res_ready_i.
// Load data is visible the cycle after load_i; the producer only loads while the entry is empty.
module fir_seq_res_reg #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          load_i,
  input  logic [DW-1:0] load_data_i,
  input  logic          res_ready_i,
  output logic          res_valid_o,
  output logic [DW-1:0] res_data_o
);

  logic          vld_q, vld_d;
  logic [DW-1:0] dat_q, dat_d;

  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (vld_q && res_ready_i) begin
      vld_d = 1'b0;
    end
    if (load_i) begin
      vld_d = 1'b1;
      dat_d = load_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign res_valid_o = vld_q;
  assign res_data_o  = dat_q;

endmodule

// File: rtl/fir_seq.sv
// Sequencer driving the fir control port: winds coefficients, primes the delay line, runs computes.
// Accepted beats reach fir_* one cycle later; samples stall while a result is held or after a timeout.
module fir_seq
  import fir_pkg::*;
#(
  parameter int TAPS       = FIR_TAPS,
  parameter int DW         = FIR_DW,
  parameter int RUN_CYCLES = 6,
  parameter int WAIT_MAX   = 64
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          flush,
  input  logic          coef_valid,
  output logic          coef_ready,
  input  logic [DW-1:0] coef_data,
  input  logic          smp_valid,
  output logic          smp_ready,
  input  logic [DW-1:0] smp_data,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          fir_wind,
  output logic          fir_load,
  output logic          fir_in_valid,
  output logic [DW-1:0] fir_data,
  input  logic          fir_out_valid,
  input  logic [DW-1:0] fir_out,
  output logic          coef_loaded,
  output logic          busy,
  output logic          err_timeout
);

  localparam int BW = cnt_w(TAPS);
  localparam int RW = cnt_w(RUN_CYCLES);
  localparam int TW = cnt_w(WAIT_MAX);

  localparam logic [BW-1:0] TAPS_C   = BW'(TAPS);
  localparam logic [BW-1:0] FILL_MAX = BW'(TAPS - 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(RUN_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(WAIT_MAX - 1);

  fir_seq_state_e state_q, state_d;
  logic [BW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [BW-1:0]  fill_cnt_q, fill_cnt_d;
  logic [RW-1:0]  run_cnt_q, run_cnt_d;
  logic [TW-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic           loaded_q, loaded_d;
  logic           err_q, err_d;
  logic           wind_q, wind_d;
  logic           load_q, load_d;
  logic           inv_q, inv_d;
  logic [DW-1:0]  data_q, data_d;
  logic           res_cap;

  // Coefficient reload wins over samples, so a pending coef_valid masks smp_ready.
  assign smp_ready  = (state_q == IDLE) && smp_valid && loaded_q && !err_q &&
                      !res_valid && !coef_valid && !flush;
  assign coef_ready = (state_q == WIND) && (beat_cnt_q != TAPS_C) && !flush;
  assign res_cap    = (state_q == WAIT) && fir_out_valid && !flush;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    fill_cnt_d = fill_cnt_q;
    run_cnt_d  = run_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    loaded_d   = loaded_q;
    err_d      = err_q;
    wind_d     = 1'b0;
    load_d     = 1'b0;
    inv_d      = 1'b0;
    data_d     = data_q;

    case (state_q)
      IDLE: begin
        if (coef_valid) begin
          state_d    = WIND;
          beat_cnt_d = '0;
        end else if (smp_ready) begin
          load_d  = 1'b1;
          data_d  = smp_data;
          state_d = (fill_cnt_q < FILL_MAX) ? FILL : LOAD;
        end
      end
      WIND: begin
        if (coef_valid && coef_ready) begin
          wind_d     = 1'b1;
          data_d     = coef_data;
          beat_cnt_d = beat_cnt_q + 1'b1;
        end else if (beat_cnt_q == TAPS_C) begin
          // New taps make any samples already in the line meaningless.
          loaded_d   = 1'b1;
          fill_cnt_d = '0;
          state_d    = IDLE;
        end
      end
      FILL: begin
        fill_cnt_d = fill_cnt_q + 1'b1;
        state_d    = IDLE;
      end
      LOAD: begin
        fill_cnt_d = FILL_MAX;
        run_cnt_d  = '0;
        inv_d      = 1'b1;
        state_d    = RUN;
      end
      RUN: begin
        if (run_cnt_q == RUN_LAST) begin
          tmo_cnt_d = '0;
          state_d   = WAIT;
        end else begin
          run_cnt_d = run_cnt_q + 1'b1;
          inv_d     = 1'b1;
        end
      end
      WAIT: begin
        if (fir_out_valid) begin
          state_d = IDLE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // flush acts like reset but keeps the wound taps and any held result.
    if (flush) begin
      state_d    = IDLE;
      beat_cnt_d = '0;
      fill_cnt_d = '0;
      run_cnt_d  = '0;
      tmo_cnt_d  = '0;
      err_d      = 1'b0;
      wind_d     = 1'b0;
      load_d     = 1'b0;
      inv_d      = 1'b0;
      data_d     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      fill_cnt_q <= '0;
      run_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      loaded_q   <= 1'b0;
      err_q      <= 1'b0;
      wind_q     <= 1'b0;
      load_q     <= 1'b0;
      inv_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      fill_cnt_q <= fill_cnt_d;
      run_cnt_q  <= run_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      loaded_q   <= loaded_d;
      err_q      <= err_d;
      wind_q     <= wind_d;
      load_q     <= load_d;
      inv_q      <= inv_d;
      data_q     <= data_d;
    end
  end

  fir_seq_res_reg #(
    .DW (DW)
  ) u_res_reg (
    .clk         (clk),
    .rstb        (rstb),
    .load_i      (res_cap),
    .load_data_i (fir_out),
    .res_ready_i (res_ready),
    .res_valid_o (res_valid),
    .res_data_o  (res_data)
  );

  assign fir_wind     = wind_q;
  assign fir_load     = load_q;
  assign fir_in_valid = inv_q;
  assign fir_data     = data_q;
  assign coef_loaded  = loaded_q;
  assign err_timeout  = err_q;
  assign busy         = (state_q != IDLE);

endmodule
